// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, round count, inverse-cipher FSM states,
// FIPS-197 Appendix C vectors and the GF(2^8) helpers used by the inverse round.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } inv_fsm_e;

  function automatic int aes_nr(input int nk);
    return nk + 6;
  endfunction

  // FIPS-197 Appendix C: every key size decrypts to the same plaintext.
  localparam block_t       FIPS_PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY_128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] FIPS_KEY_192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] FIPS_KEY_256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam block_t       FIPS_CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam block_t       FIPS_CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam block_t       FIPS_CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Byte n lives at bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t o;
    for (int n = 0; n < 16; n++) o[8*n +: 8] = inv_sbox(s[8*n +: 8]);
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t     o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the last round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t istate,
  input  block_t key,
  input  logic   final_rnd,
  output block_t ostate
);

  block_t shifted;
  block_t subbed;
  block_t keyed;

  assign shifted = inv_shift_rows(istate);
  assign subbed  = inv_sub_bytes(shifted);
  assign keyed   = subbed ^ key;
  assign ostate  = final_rnd ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES InvCipher: one inverse round per clock, valid/ready on both sides.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter  int Nk = 4,
  localparam int Nr = aes_nr(Nk)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [AES_BLOCK_W-1:0]       ciphertext,
  input  logic [AES_BLOCK_W*(Nr+1)-1:0] w,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AES_BLOCK_W-1:0]       plaintext,
  output logic                         busy
);

  localparam int RndW = $clog2(Nr);
  localparam int SchW = AES_BLOCK_W * (Nr + 1);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_inv_cipher_iter: Nk must be 4, 6 or 8");
  end

  inv_fsm_e        fsm_q, fsm_d;
  block_t          state_q, state_d;
  logic [SchW-1:0] w_q, w_d;
  logic [RndW-1:0] rnd_q, rnd_d;

  logic        accept;
  logic        final_rnd;
  int unsigned rnd_idx;
  block_t      rnd_key;
  block_t      round_out;

  // A finished block in DONE can be retired and replaced on the same edge.
  assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (fsm_q == ROUND);
  assign out_valid = (fsm_q == DONE);
  assign plaintext = state_q;

  assign final_rnd = (rnd_q == '0);
  assign rnd_idx   = 32'(rnd_q);
  assign rnd_key   = w_q[rnd_idx*AES_BLOCK_W +: AES_BLOCK_W];

  aes_inv_round u_round (
    .istate    (state_q),
    .key       (rnd_key),
    .final_rnd (final_rnd),
    .ostate    (round_out)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    fsm_d   = fsm_q;
    state_d = state_q;
    w_d     = w_q;
    rnd_d   = rnd_q;
    unique case (fsm_q)
      IDLE, DONE: begin
        if (accept) begin
          fsm_d   = ROUND;
          state_d = ciphertext ^ w[Nr*AES_BLOCK_W +: AES_BLOCK_W];
          w_d     = w;
          rnd_d   = RndW'(Nr - 1);
        end else if ((fsm_q == DONE) && out_ready) begin
          fsm_d = IDLE;
        end
      end
      ROUND: begin
        state_d = round_out;
        if (final_rnd) fsm_d = DONE;
        else           rnd_d = rnd_q - RndW'(1);
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      // NOTE: the captured key schedule is flops, not a RAM, so it is cleared
      // with everything else and no stale key survives a reset.
      w_q     <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      w_q     <= w_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: Nk=4/6/8 instances checked against a forward-cipher model.
module tb_aes_inv_cipher_iter;
  import aes_pkg::*;

  localparam int NDUT  = 3;
  localparam int W_MAX = 128 * 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                  in_valid  [NDUT];
  logic                  in_ready  [NDUT];
  logic                  out_valid [NDUT];
  logic                  out_ready [NDUT];
  logic                  busy      [NDUT];
  logic [127:0]          ct        [NDUT];
  logic [127:0]          pt        [NDUT];
  logic [128*11-1:0]     w4;
  logic [128*13-1:0]     w6;
  logic [128*15-1:0]     w8;

  aes_inv_cipher_iter #(.Nk(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .ciphertext(ct[0]), .w(w4), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .plaintext(pt[0]), .busy(busy[0]));
  aes_inv_cipher_iter #(.Nk(6)) u_dut6 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .ciphertext(ct[1]), .w(w6), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .plaintext(pt[1]), .busy(busy[1]));
  aes_inv_cipher_iter #(.Nk(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .ciphertext(ct[2]), .w(w8), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .plaintext(pt[2]), .busy(busy[2]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model (forward cipher) ----------------
  logic [7:0] sbox_tbl [256];

  function automatic logic [7:0] m_xtime(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, r;
    x = a; y = b; r = 8'h00;
    while (y != 8'h00) begin
      if (y[0]) r = r ^ x;
      x = m_xtime(x);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox_tbl[v[31:24]], sbox_tbl[v[23:16]], sbox_tbl[v[15:8]], sbox_tbl[v[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; round key r lands at [r*128 +: 128].
  function automatic logic [W_MAX-1:0] expand(input int nk, input logic [255:0] key);
    logic [31:0]      wd [60];
    logic [31:0]      tmp;
    logic [7:0]       rcon;
    logic [W_MAX-1:0] res;
    rcon = 8'h01;
    res  = '0;
    for (int i = 0; i < 60; i++) wd[i] = '0;
    for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      tmp = wd[i-1];
      if (i % nk == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = m_xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      wd[i] = wd[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nk + 6; r++)
      res[r*128 +: 128] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] encrypt(input int nk, input logic [W_MAX-1:0] rk,
                                           input logic [127:0] p);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a [4];
    logic [127:0] o;
    int nr;
    nr = nk + 6;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = p[127-8*(4*c+r) -: 8] ^ rk[127-8*(4*c+r) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sbox_tbl[s[r][(c+r)%4]];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = t[r][c];
          t[0][c] = m_mul(8'h02, a[0]) ^ m_mul(8'h03, a[1]) ^ a[2] ^ a[3];
          t[1][c] = a[0] ^ m_mul(8'h02, a[1]) ^ m_mul(8'h03, a[2]) ^ a[3];
          t[2][c] = a[0] ^ a[1] ^ m_mul(8'h02, a[2]) ^ m_mul(8'h03, a[3]);
          t[3][c] = m_mul(8'h03, a[0]) ^ a[1] ^ a[2] ^ m_mul(8'h02, a[3]);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = t[r][c] ^ rk[rnd*128 + 127 - 8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [W_MAX-1:0] rand_w();
    logic [W_MAX-1:0] v;
    for (int i = 0; i < 15; i++) v[i*128 +: 128] = rand128();
    return v;
  endfunction

  task automatic make_job(input int nk, output logic [W_MAX-1:0] sched,
                          output logic [127:0] c, output logic [127:0] p);
    logic [255:0] key;
    key   = {rand128(), rand128()};
    p     = rand128();
    sched = expand(nk, key);
    c     = encrypt(nk, sched, p);
  endtask

  // ---------------- DUT drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [127:0] c,
                       input logic [W_MAX-1:0] s);
    in_valid[d] = v;
    ct[d]       = c;
    case (d)
      0:       w4 = s[128*11-1:0];
      1:       w6 = s[128*13-1:0];
      default: w8 = s[128*15-1:0];
    endcase
  endtask

  // Present one job, scramble the inputs right after the accept, measure latency, retire.
  task automatic run_job(input int d, input logic [127:0] c, input logic [W_MAX-1:0] sched,
                         output int lat, output logic [127:0] res);
    int n;
    drive(d, 1'b1, c, sched);
    n = 0;
    while (!in_ready[d] && n < 100) begin tick(); n++; end
    tick();
    drive(d, 1'b0, rand128(), rand_w());
    lat = 0;
    while (!out_valid[d] && lat < 100) begin tick(); lat++; end
    res = pt[d];
    tick();
  endtask

  typedef struct {
    int           nk;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [9];

  task automatic test_table();
    int           lat, d;
    logic [127:0] res;
    for (int i = 0; i < 9; i++) begin
      d = (vecs[i].nk - 4) / 2;
      run_job(d, vecs[i].ct, expand(vecs[i].nk, vecs[i].key), lat, res);
      check($sformatf("vec%0d_nk%0d_pt", i, vecs[i].nk), res, vecs[i].pt);
      check($sformatf("vec%0d_nk%0d_latency", i, vecs[i].nk), 128'(lat), 128'(vecs[i].nk + 6));
    end
  endtask

  task automatic test_b2b(input int n);
    logic [127:0]     exp_q [$];
    logic [W_MAX-1:0] sched;
    logic [127:0]     c, p;
    logic             fire_in, fire_out;
    int accepts, got, last_acc, cyc;
    accepts = 0; got = 0; last_acc = 0; cyc = 0;
    out_ready[0] = 1'b1;
    make_job(4, sched, c, p);
    exp_q.push_back(p);
    drive(0, 1'b1, c, sched);
    while (got < n && cyc < n * 20 + 40) begin
      @(negedge clk);
      fire_in  = in_valid[0] && in_ready[0];
      fire_out = out_valid[0] && out_ready[0];
      if (fire_out) begin
        if (exp_q.size() == 0) check("b2b_unexpected_output", pt[0], 128'hx);
        else                   check($sformatf("b2b_pt%0d", got), pt[0], exp_q.pop_front());
        got++;
      end
      tick();
      cyc++;
      if (fire_in) begin
        if (accepts > 0) check($sformatf("b2b_spacing%0d", accepts), 128'(cyc - last_acc), 128'(11));
        last_acc = cyc;
        accepts++;
        if (accepts < n) begin
          make_job(4, sched, c, p);
          exp_q.push_back(p);
          drive(0, 1'b1, c, sched);
        end else begin
          drive(0, 1'b0, rand128(), rand_w());
        end
      end
    end
    check("b2b_result_count", 128'(got), 128'(n));
  endtask

  task automatic test_stall();
    logic [W_MAX-1:0] sched;
    logic [127:0]     c, p, held;
    int n, stable;
    make_job(4, sched, c, p);
    out_ready[0] = 1'b0;
    drive(0, 1'b1, c, sched);
    tick();
    drive(0, 1'b0, rand128(), rand_w());
    n = 0;
    while (!out_valid[0] && n < 100) begin tick(); n++; end
    check("stall_latency", 128'(n), 128'(10));
    check("stall_pt", pt[0], p);
    held   = pt[0];
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid[0] && !in_ready[0] && pt[0] === held) stable++;
      tick();
    end
    check("stall_stable_cycles", 128'(stable), 128'(20));
    out_ready[0] = 1'b1;
    #1;
    check("stall_release_in_ready", 128'(in_ready[0]), 128'(1));
    tick();
    check("stall_after_out_valid", 128'(out_valid[0]), 128'(0));
    check("stall_after_busy", 128'(busy[0]), 128'(0));
  endtask

  task automatic test_in_round();
    logic [W_MAX-1:0] sa, sb;
    logic [127:0]     ca, pa, cb, pb;
    int n, leaks;
    make_job(4, sa, ca, pa);
    make_job(4, sb, cb, pb);
    out_ready[0] = 1'b1;
    drive(0, 1'b1, ca, sa);
    tick();
    drive(0, 1'b1, cb, sb);
    n = 0; leaks = 0;
    while (!out_valid[0] && n < 100) begin
      if (in_ready[0]) leaks++;
      tick();
      n++;
    end
    check("inround_ready_leaks", 128'(leaks), 128'(0));
    check("inround_a_latency", 128'(n), 128'(10));
    check("inround_a_pt", pt[0], pa);
    check("inround_done_in_ready", 128'(in_ready[0]), 128'(1));
    tick();
    drive(0, 1'b0, rand128(), rand_w());
    check("inround_b_no_bubble", 128'(busy[0]), 128'(1));
    n = 0;
    while (!out_valid[0] && n < 100) begin tick(); n++; end
    check("inround_b_latency", 128'(n), 128'(10));
    check("inround_b_pt", pt[0], pb);
    tick();
  endtask

  task automatic test_reset();
    logic [W_MAX-1:0] sched;
    logic [127:0]     c, p, res;
    int lat, seen;
    make_job(4, sched, c, p);
    out_ready[0] = 1'b1;
    drive(0, 1'b1, c, sched);
    tick();
    drive(0, 1'b0, rand128(), rand_w());
    repeat (5) tick();
    #3;
    reset = 1'b1;
    #1;
    check("rst_mid_out_valid", 128'(out_valid[0]), 128'(0));
    check("rst_mid_busy", 128'(busy[0]), 128'(0));
    check("rst_mid_plaintext", pt[0], 128'h0);
    check("rst_mid_in_ready", 128'(in_ready[0]), 128'(1));
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid[0]) seen++;
      tick();
    end
    check("rst_no_out_valid", 128'(seen), 128'(0));
    run_job(0, FIPS_CT_128, expand(4, {FIPS_KEY_128, 128'h0}), lat, res);
    check("rst_after_fips_pt", res, FIPS_PT);
    check("rst_after_fips_latency", 128'(lat), 128'(10));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      ct[d]        = '0;
    end
    w4 = '0; w6 = '0; w8 = '0;
    build_sbox();

    vecs[0] = '{nk: 4, key: {FIPS_KEY_128, 128'h0}, ct: FIPS_CT_128, pt: FIPS_PT};
    vecs[1] = '{nk: 6, key: {FIPS_KEY_192, 64'h0},  ct: FIPS_CT_192, pt: FIPS_PT};
    vecs[2] = '{nk: 8, key: FIPS_KEY_256,           ct: FIPS_CT_256, pt: FIPS_PT};
    for (int i = 3; i < 9; i++) begin
      vecs[i].nk  = 4 + 2 * ((i - 3) % 3);
      vecs[i].key = {rand128(), rand128()};
      vecs[i].pt  = rand128();
      vecs[i].ct  = encrypt(vecs[i].nk, expand(vecs[i].nk, vecs[i].key), vecs[i].pt);
    end

    #7;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_in_ready%0d", d), 128'(in_ready[d]), 128'(1));
      check($sformatf("reset_out_valid%0d", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("reset_busy%0d", d), 128'(busy[d]), 128'(0));
      check($sformatf("reset_plaintext%0d", d), pt[d], 128'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    test_table();
    test_b2b(8);
    test_stall();
    test_in_round();
    test_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative, parametrised AES inverse cipher (FIPS-197 InvCipher) for AES-128/192/256, selected by `Nk`. It computes one inverse round per clock on a single round datapath, replacing a fully unrolled combinational decryptor. It sits between the SPI receive path, which supplies the ciphertext, and the SPI transmit path, which consumes the plaintext. The key schedule comes from the key-expansion block. Valid/ready handshakes sit on both sides.

## Interface
Parameters:
- `Nk`, default 4: key length in 32-bit words. Legal values are 4, 6 and 8; any other value is an elaboration error.
- `Nr`, derived as Nk+6 (10/12/14): number of rounds. Local only, not overridable.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: ciphertext and key schedule are presented.
- `in_ready`, output, 1: block can accept a new job.
- `ciphertext`, input, 128: bits [127:120] are byte 0.
- `w`, input, 128*(Nr+1): expanded key schedule. Round key r is `w[r*128 +: 128]`.
- `out_valid`, output, 1: plaintext is valid.
- `out_ready`, input, 1: downstream accepts the plaintext.
- `plaintext`, output, 128: decrypted block, same byte order as `ciphertext`.
- `busy`, output, 1: a job is in progress (ROUND state).

## Operation
- FSM has three states: IDLE, ROUND, DONE. Reset enters IDLE.
- Accept is `in_valid && in_ready`. On accept:
  - `state_q <= ciphertext ^ w[Nr]`
  - the full `w` is registered into `w_q`; the inputs may change afterwards
  - `rnd_q <= Nr-1`
  - FSM goes to ROUND.
- In ROUND, each cycle applies InvShiftRows → InvSubBytes → AddRoundKey(`w_q[rnd_q]`) → InvMixColumns, and decrements `rnd_q`.
- When `rnd_q == 0`, the cycle applies the final round instead: InvMixColumns is skipped, the key is `w_q[0]`, and the FSM goes to DONE.
- In DONE, `out_valid=1` and `plaintext=state_q`. Both hold stable until `out_ready`.
- `in_ready` is 1 in IDLE, and 1 in DONE while `out_ready` is 1 (combinational from `out_ready`). It is 0 in ROUND.
- Simultaneous output handshake and new accept in DONE: the current result is retired and the new job is loaded that same edge. The FSM goes straight to ROUND with no IDLE bubble.
- Output handshake in DONE with no new job: FSM goes to IDLE.
- `in_valid` during ROUND is ignored and is not lost by the block. The source must hold it until `in_ready`.
- Reset mid-job: the job is discarded, FSM returns to IDLE, and all registers are cleared immediately (asynchronously).
- `rnd_q` width is $clog2(Nr). It never wraps; ROUND always exits at 0.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `busy=0`, `plaintext=0`, `state_q=0`, `w_q=0`, `rnd_q=0`.
- Latency: if the accept is on edge k, `out_valid` rises after edge k+Nr. That is 10, 12 or 14 cycles.
- Throughput:
  - back-to-back with `out_ready` held high: one block every Nr+1 cycles
  - with the output never stalled and a gap between jobs: Nr+2 cycles
- `plaintext` and `out_valid` are registered. `in_ready` has a combinational path from `out_ready` only.
- Critical path: one inverse round (InvSubBytes LUT + InvMixColumns + key XOR) plus a 128-bit mux on `w_q`, selected by `rnd_q`.

## Structure
- Shared package `aes_pkg`:
  - `AES_BLOCK_W = 128`
  - function `aes_nr(nk)` returning nk+6
  - FSM state enum `inv_fsm_e` (IDLE, ROUND, DONE)
  - FIPS-197 Appendix C test constants, used by the bench
- One sub-module: `aes_inv_round`. It is combinational, with ports `istate`, `key`, `final_rnd` and `ostate`. It instantiates the existing InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. `final_rnd` bypasses InvMixColumns.
- Top level contains the FSM, `state_q`, `w_q`, `rnd_q` and the round-key mux.

## Test plan
- Nk=4, key 000102…0f (schedule from the bench model), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → plaintext 00112233445566778899aabbccddeeff. `out_valid` rises exactly 10 cycles after accept.
- Nk=6, key 000102…17, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191 → same plaintext, after 12 cycles. Nk=8, key 000102…1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 → same plaintext, after 14 cycles.
- Nk=4, 8 random blocks back-to-back with `out_ready=1` and the inputs changed right after each accept. All results match the reference model, and accepts are spaced exactly 11 cycles apart.
- Output stall: hold `out_ready=0` for 20 cycles in DONE. `plaintext` and `out_valid` stay stable, and `in_ready=0` throughout. Release → one handshake, then IDLE.
- Assert `in_valid` during ROUND with different data. That data is not taken and the current result is unchanged. The job is accepted only once the FSM reaches IDLE or DONE.
- Assert `reset` for 1 cycle at round 5 of a job. Outputs return to their reset values asynchronously and no `out_valid` appears. The next job (Appendix C vector) decrypts correctly.
